// File: rtl/adpll_pkg.sv
// rtl/adpll_pkg.sv - shared types and default constants for the ADPLL lock controller
package adpll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COARSE = 2'd1,
    ST_FINE   = 2'd2,
    ST_LOCKED = 2'd3
  } adpll_state_e;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } adpll_dir_e;

  localparam int ADPLL_CODE_W     = 8;
  localparam int ADPLL_LOCK_CNT   = 16;
  localparam int ADPLL_UNLOCK_RUN = 8;

endpackage

// File: rtl/adpll_lock_ctrl_if.sv
// rtl/adpll_lock_ctrl_if.sv - BBPD decision inputs and DCO/status outputs of the lock controller
interface adpll_lock_ctrl_if #(
  parameter int CODE_W = adpll_pkg::ADPLL_CODE_W
);
  import adpll_pkg::*;

  logic              pd_valid;
  logic              pd_late;
  logic              pd_early;
  logic [CODE_W-1:0] dco_code;
  logic              code_upd;
  logic              locked;
  adpll_state_e      state;

  modport master (
    output pd_valid, pd_late, pd_early,
    input  dco_code, code_upd, locked, state
  );

  modport slave (
    input  pd_valid, pd_late, pd_early,
    output dco_code, code_upd, locked, state
  );

endinterface

// File: rtl/adpll_lock_det.sv
// rtl/adpll_lock_det.sv - direction-flip and same-direction-run counters for lock/unlock decisions
module adpll_lock_det
  import adpll_pkg::*;
#(
  parameter int LOCK_CNT   = ADPLL_LOCK_CNT,
  parameter int UNLOCK_RUN = ADPLL_UNLOCK_RUN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       dec_valid,
  input  adpll_dir_e dir,
  input  logic       in_locked,
  output logic       lock_hit,
  output logic       unlock_hit
);

  localparam int FW = $clog2(LOCK_CNT + 1);
  localparam int RW = $clog2(UNLOCK_RUN + 1);

  logic          have_last;
  adpll_dir_e    last_dir;
  logic [FW-1:0] flip_cnt;
  logic [RW-1:0] run_cnt;
  logic          is_flip;
  logic [RW-1:0] run_next;

  assign is_flip    = have_last && (dir != last_dir);
  // A flip starts a new run of length one, so any 8 equal decisions in a row unlock.
  assign run_next   = is_flip ? RW'(1) : run_cnt + RW'(1);
  assign lock_hit   = dec_valid && !in_locked && is_flip && (flip_cnt == FW'(LOCK_CNT - 1));
  assign unlock_hit = dec_valid && in_locked && (run_next == RW'(UNLOCK_RUN));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      have_last <= 1'b0;
      last_dir  <= DIR_DN;
      flip_cnt  <= '0;
      run_cnt   <= '0;
    end else if (dec_valid) begin
      have_last <= 1'b1;
      last_dir  <= dir;
      if (in_locked) begin
        if (unlock_hit) begin
          have_last <= 1'b0;
          flip_cnt  <= '0;
          run_cnt   <= '0;
        end else begin
          run_cnt <= run_next;
        end
      end else if (lock_hit) begin
        flip_cnt <= '0;
        run_cnt  <= '0;
      end else if (is_flip) begin
        flip_cnt <= flip_cnt + FW'(1);
      end else begin
        flip_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/adpll_lock_ctrl.sv
// rtl/adpll_lock_ctrl.sv - ADPLL coarse binary search, fine tracking and lock supervision
// Optional holdover freeze in FINE/LOCKED is built when ADPLL_HOLDOVER_EN is defined.
module adpll_lock_ctrl
  import adpll_pkg::*;
#(
  parameter int CODE_W     = ADPLL_CODE_W,
  parameter int CODE_INIT  = 2**(CODE_W-1),
  parameter int LOCK_CNT   = ADPLL_LOCK_CNT,
  parameter int UNLOCK_RUN = ADPLL_UNLOCK_RUN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hold,
  adpll_lock_ctrl_if.slave bus
);

  localparam logic [CODE_W-1:0] CODE_RST = CODE_W'(CODE_INIT);
  localparam logic [CODE_W-1:0] CODE_MAX = '1;
  localparam logic [CODE_W-2:0] STEP_RST = (CODE_W-1)'(2**(CODE_W-2));

  adpll_state_e      state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-2:0] step_q, step_d;
  logic              locked_q, locked_d;
  logic              upd_q;
  logic              dec, tracking, hold_eff, at_rail, rail_hit;
  logic              det_valid, det_clear, lock_hit, unlock_hit;
  adpll_dir_e        dir;
  logic [CODE_W:0]   sum_w, dif_w;

  assign dec      = bus.pd_valid & (bus.pd_late ^ bus.pd_early);
  assign dir      = bus.pd_late ? DIR_UP : DIR_DN;
  assign tracking = (state_q == ST_FINE) || (state_q == ST_LOCKED);

`ifdef ADPLL_HOLDOVER_EN
  assign hold_eff = hold & tracking;
`else
  assign hold_eff = hold & 1'b0;
`endif

  assign at_rail   = (dir == DIR_UP) ? (code_q == CODE_MAX) : (code_q == '0);
  assign det_valid = en & tracking & dec & ~hold_eff;
  assign rail_hit  = det_valid & at_rail;
  assign det_clear = ~en | ~tracking | rail_hit;

  // One extra bit so the coarse step can be saturated at either rail.
  assign sum_w = {1'b0, code_q} + (CODE_W+1)'(step_q);
  assign dif_w = {1'b0, code_q} - (CODE_W+1)'(step_q);

  adpll_lock_det #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_RUN (UNLOCK_RUN)
  ) u_lock_det (
    .clk        (clk),
    .rst        (rst),
    .clear      (det_clear),
    .dec_valid  (det_valid),
    .dir        (dir),
    .in_locked  (state_q == ST_LOCKED),
    .lock_hit   (lock_hit),
    .unlock_hit (unlock_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      code_q   <= CODE_RST;
      step_q   <= STEP_RST;
      locked_q <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      step_q   <= step_d;
      locked_q <= locked_d;
      upd_q    <= (code_d != code_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    step_d   = step_q;
    locked_d = locked_q;
    if (!en) begin
      state_d  = ST_IDLE;
      code_d   = CODE_RST;
      step_d   = STEP_RST;
      locked_d = 1'b0;
    end else if (!hold_eff) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_COARSE;
          code_d  = CODE_RST;
          step_d  = STEP_RST;
        end
        ST_COARSE: begin
          if (dec) begin
            if (dir == DIR_UP) code_d = sum_w[CODE_W] ? CODE_MAX : sum_w[CODE_W-1:0];
            else               code_d = dif_w[CODE_W] ? '0 : dif_w[CODE_W-1:0];
            step_d = step_q >> 1;
            if (step_q == (CODE_W-1)'(1)) state_d = ST_FINE;
          end
        end
        ST_FINE, ST_LOCKED: begin
          if (rail_hit) begin
            state_d  = ST_COARSE;
            code_d   = CODE_RST;
            step_d   = STEP_RST;
            locked_d = 1'b0;
          end else if (dec) begin
            code_d = (dir == DIR_UP) ? code_q + CODE_W'(1) : code_q - CODE_W'(1);
            if (lock_hit) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
            if (unlock_hit) begin
              state_d  = ST_FINE;
              locked_d = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.dco_code = code_q;
  assign bus.code_upd = upd_q;
  assign bus.locked   = locked_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// tb/tb_adpll_lock_ctrl.sv - self-checking bench for adpll_lock_ctrl (vector table, sequences, random vs model)
// Holdover checks follow ADPLL_HOLDOVER_EN when the bench is built with it.
module tb_adpll_lock_ctrl;
  import adpll_pkg::*;

  localparam int CW    = 8;
  localparam int INIT  = 2**(CW-1);
  localparam int MAXC  = 2**CW - 1;
  localparam int STEP0 = 2**(CW-2);
  localparam int LCNT  = 16;
  localparam int URUN  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic hold = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  adpll_lock_ctrl_if #(.CODE_W(CW)) bus ();

  adpll_lock_ctrl #(.CODE_W(CW)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .hold (hold),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural reference: integers following the acquisition rules directly.
  int m_state, m_code, m_step, m_locked, m_upd;
  int m_have, m_last, m_flips, m_run;

  function automatic void m_clear();
    m_have = 0; m_last = 0; m_flips = 0; m_run = 0;
  endfunction

  function automatic void m_apply(input logic r, input logic e_n, input logic h,
                                  input logic v, input logic l, input logic ea);
    int prev;
    bit is_dec, up, frozen;
    prev   = m_code;
    is_dec = v && (l != ea);
    up     = l;
    frozen = 0;
`ifdef ADPLL_HOLDOVER_EN
    frozen = h && (m_state >= 2);
`else
    frozen = h && 1'b0;
`endif
    if (r) begin
      m_state = 0; m_code = INIT; m_step = STEP0; m_locked = 0; m_upd = 0; m_clear();
      return;
    end
    if (!e_n) begin
      m_state = 0; m_code = INIT; m_step = STEP0; m_locked = 0; m_clear();
    end else if (!frozen) begin
      if (m_state == 0) begin
        m_state = 1; m_code = INIT; m_step = STEP0;
      end else if (m_state == 1) begin
        if (is_dec) begin
          m_code = up ? m_code + m_step : m_code - m_step;
          if (m_code > MAXC) m_code = MAXC;
          if (m_code < 0) m_code = 0;
          if (m_step == 1) m_state = 2;
          m_step = m_step / 2;
          m_clear();
        end
      end else if (is_dec) begin
        if ((up && m_code == MAXC) || (!up && m_code == 0)) begin
          m_state = 1; m_code = INIT; m_step = STEP0; m_locked = 0; m_clear();
        end else begin
          m_code = up ? m_code + 1 : m_code - 1;
          if (m_state == 2) begin
            if (!m_have) m_flips = 0;
            else if (int'(up) != m_last) m_flips++;
            else m_flips = 0;
            m_have = 1; m_last = int'(up);
            if (m_flips == LCNT) begin
              m_state = 3; m_locked = 1; m_flips = 0; m_run = 0;
            end
          end else begin
            m_run  = (int'(up) == m_last) ? m_run + 1 : 1;
            m_last = int'(up);
            if (m_run == URUN) begin
              m_state = 2; m_locked = 0; m_clear();
            end
          end
        end
      end
    end
    m_upd = (m_code != prev) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e_n, input logic h,
                       input logic v, input logic l, input logic ea);
    rst = r; en = e_n; hold = h;
    bus.pd_valid = v; bus.pd_late = l; bus.pd_early = ea;
    @(posedge clk);
    #1;
    m_apply(r, e_n, h, v, l, ea);
    chk("model_code",   32'(bus.dco_code), 32'(m_code));
    chk("model_upd",    32'(bus.code_upd), 32'(m_upd));
    chk("model_state",  32'(bus.state),    32'(m_state));
    chk("model_locked", 32'(bus.locked),   32'(m_locked));
  endtask

  task automatic expect_now(input string name, input int st, input int code,
                            input int lk, input int upd);
    chk({name, "_state"},  32'(bus.state),    32'(st));
    chk({name, "_code"},   32'(bus.dco_code), 32'(code));
    chk({name, "_locked"}, 32'(bus.locked),   32'(lk));
    chk({name, "_upd"},    32'(bus.code_upd), 32'(upd));
  endtask

  task automatic up(input logic h);   drive(0, 1, h, 1, 1, 0); endtask
  task automatic dn(input logic h);   drive(0, 1, h, 1, 0, 1); endtask
  task automatic both();              drive(0, 1, 0, 1, 1, 1); endtask
  task automatic none();              drive(0, 1, 0, 1, 0, 0); endtask

  task automatic reset_en();
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
  endtask

  // Coarse path U,D,D,D,D,D,D ends at 129, then 17 alternating decisions from UP.
  task automatic go_locked();
    reset_en();
    up(0);
    for (int k = 0; k < 6; k++) dn(0);
    expect_now("fine_mid", 2, 129, 0, 1);
    for (int i = 0; i < 17; i++) begin
      if (i % 2 == 0) up(0); else dn(0);
      if (i == 8) begin
        both();
        expect_now("fine_both", 2, 130, 0, 0);
        none();
        expect_now("fine_none", 2, 130, 0, 0);
      end
      if (i == 15) expect_now("pre_lock", 2, 129, 0, 1);
    end
    expect_now("lock", 3, 130, 1, 1);
  endtask

  typedef struct {
    logic v, l, e;
    int   code;
    logic upd;
    int   st;
    logic lk;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bus.pd_valid = 1'b0; bus.pd_late = 1'b0; bus.pd_early = 1'b0;
    m_state = 0; m_code = INIT; m_step = STEP0; m_locked = 0; m_upd = 0; m_clear();

    // Reset state and IDLE ignoring decisions while disabled
    drive(1, 0, 0, 0, 0, 0);
    expect_now("reset", 0, INIT, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    expect_now("idle_dis", 0, INIT, 0, 0);

    // Table: coarse UP search with invalid decisions interleaved
    tbl = '{
      '{0, 0, 0, 128, 0, 1, 0},
      '{1, 1, 0, 192, 1, 1, 0},
      '{1, 1, 1, 192, 0, 1, 0},
      '{1, 0, 0, 192, 0, 1, 0},
      '{0, 1, 0, 192, 0, 1, 0},
      '{1, 1, 0, 224, 1, 1, 0},
      '{1, 1, 0, 240, 1, 1, 0},
      '{1, 1, 0, 248, 1, 1, 0},
      '{1, 1, 0, 252, 1, 1, 0},
      '{1, 1, 0, 254, 1, 1, 0},
      '{1, 1, 0, 255, 1, 2, 0},
      '{1, 1, 1, 255, 0, 2, 0},
      '{1, 0, 0, 255, 0, 2, 0},
      '{1, 0, 1, 254, 1, 2, 0}
    };
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(0, 1, 0, tbl[i].v, tbl[i].l, tbl[i].e);
      expect_now($sformatf("vec%0d", i), tbl[i].st, tbl[i].code, tbl[i].lk, tbl[i].upd);
    end

    // Coarse DN search, then lower rail reacquire
    reset_en();
    for (int k = 0; k < 7; k++) begin
      dn(0);
      chk($sformatf("dn_code%0d", k), 32'(bus.dco_code), 32'(INIT >> (k + 1)));
    end
    expect_now("dn_fine", 2, 1, 0, 1);
    dn(0);
    expect_now("dn_zero", 2, 0, 0, 1);
    dn(0);
    expect_now("rail", 1, INIT, 0, 1);

    // Lock, invalid decisions in LOCKED, then unlock after 8 same-direction
    go_locked();
    both();
    expect_now("lk_both", 3, 130, 1, 0);
    none();
    expect_now("lk_none", 3, 130, 1, 0);
    for (int k = 0; k < 8; k++) begin
      up(0);
      if (k == 6) expect_now("run7", 3, 137, 1, 1);
    end
    expect_now("unlock", 2, 138, 0, 1);

    // en=0 and rst each beat a coincident decision in LOCKED
    go_locked();
    drive(0, 0, 0, 1, 1, 0);
    expect_now("en_off", 0, INIT, 0, 1);
    go_locked();
    drive(1, 1, 0, 1, 1, 0);
    expect_now("rst_lk", 0, INIT, 0, 0);

    // Holdover
    go_locked();
    for (int k = 0; k < 10; k++) begin
      up(1);
`ifndef ADPLL_HOLDOVER_EN
      if (k == 7) expect_now("nohold_unlock", 2, 138, 0, 1);
`endif
    end
`ifdef ADPLL_HOLDOVER_EN
    expect_now("hold_frozen", 3, 130, 1, 0);
    up(0);
    expect_now("hold_resume", 3, 131, 1, 1);
`else
    expect_now("nohold_end", 2, 140, 0, 1);
`endif

    // Randomized run against the model; direction bias switches to reach both lock and unlock
    begin
      logic ld = 1'b0;
      int   alt_pct = 90;
      for (int c = 0; c < 6000; c++) begin
        logic r, e_n, h, v, l, ea;
        int   kind;
        if (c % 300 == 0) alt_pct = (alt_pct == 90) ? 30 : 90;
        r    = ($urandom_range(0, 999) < 2);
        e_n  = ($urandom_range(0, 199) != 0);
        h    = ($urandom_range(0, 99) < 8);
        v    = ($urandom_range(0, 3) != 0);
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
          l = 1'b1; ea = 1'b1;
        end else if (kind == 1) begin
          l = 1'b0; ea = 1'b0;
        end else begin
          if ($urandom_range(0, 99) < alt_pct) ld = ~ld;
          l = ld; ea = ~ld;
        end
        drive(r, e_n, h, v, l, ea);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adpll_lock_ctrl.md
Name: adpll_lock_ctrl

Overview:
Acquisition and tracking controller for the ADPLL/CDR oscillator. It consumes bang-bang phase detector (BBPD) decisions and sequences the DCO control word through three phases: binary-search coarse acquisition, ±1 fine tracking, then locked monitoring. It declares lock and loss of lock. It sits between the BBPD and the DCO inside the top-level wrapper.

Parameters:
- CODE_W, 8: DCO control word width; legal range 4..12.
- CODE_INIT, 2**(CODE_W-1): code loaded in IDLE and on reacquire.
- LOCK_CNT, 16: consecutive direction flips required to declare lock.
- UNLOCK_RUN, 8: consecutive same-direction decisions that drop lock.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- en, input, 1: loop enable.
- pd_valid, input, 1: one-cycle strobe; a BBPD decision is present.
- pd_late, input, 1: DCO lags; request code increase.
- pd_early, input, 1: DCO leads; request code decrease.
- hold, input, 1: holdover request; used only with ADPLL_HOLDOVER_EN.
- dco_code, output, CODE_W: DCO control word (registered).
- code_upd, output, 1: one-cycle pulse in the cycle dco_code changed.
- locked, output, 1: lock indicator (registered).
- state, output, 2: 0 IDLE, 1 COARSE, 2 FINE, 3 LOCKED.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst, named as the codebase names its reset.
- Reset values: state=IDLE, dco_code=CODE_INIT, locked=0, code_upd=0, step=2**(CODE_W-2), all counters 0.
- Decision definition: a decision is pd_valid=1 with exactly one of pd_late/pd_early set.
  - pd_late=1 means UP; pd_early=1 means DN.
  - Both set or neither set: no decision. Nothing changes and no counter moves.
- Latency: a decision sampled at edge N is reflected on dco_code and code_upd after edge N, i.e. one cycle.
- IDLE:
  - dco_code is held at CODE_INIT.
  - en=1 moves to COARSE on the next edge.
- COARSE (binary search):
  - Each decision applies dco_code ± step, then halves step.
  - The decision applied with step=1 moves the state to FINE.
  - This gives exactly CODE_W-1 decisions.
  - Arithmetic is done at CODE_W+1 bits and saturated to [0, 2**CODE_W-1].
- FINE:
  - Each decision applies ±1 with saturation. last_dir is recorded.
  - flip_cnt increments when the direction differs from last_dir; it resets to 0 on a repeat.
  - The first decision after entry only loads last_dir.
  - flip_cnt reaching LOCK_CNT moves to LOCKED; locked=1 from the same edge.
- LOCKED:
  - ±1 tracking continues.
  - run_cnt counts consecutive same-direction decisions and resets on a flip.
  - run_cnt reaching UNLOCK_RUN moves to FINE with locked=0, flip_cnt=0, run_cnt=0.
- Rail hit in FINE or LOCKED: a decision that would push past 0 or the maximum code does not move the code. Instead:
  - state goes to COARSE,
  - dco_code=CODE_INIT, step reset,
  - locked=0, code_upd=1.
- en=0 in any state: IDLE on the next edge, dco_code=CODE_INIT, locked=0, counters cleared. en=0 has priority over a coincident decision.
- code_upd is 1 only when the registered code value actually changes.

Optional Feature:
ADPLL_HOLDOVER_EN
- Defined:
  - hold=1 in FINE or LOCKED freezes dco_code, locked, state and all counters. Decisions are ignored.
  - hold is ignored in IDLE and COARSE.
  - en=0 and rst override hold.
- Undefined: the hold port exists but is ignored (tied off internally).

Decomposition:
- Package adpll_pkg:
  - state enum (IDLE/COARSE/FINE/LOCKED, 2-bit),
  - direction enum,
  - default CODE_W/LOCK_CNT/UNLOCK_RUN constants.
- One sub-module, adpll_lock_det: holds last_dir, flip_cnt and run_cnt. It outputs lock_hit and unlock_hit pulses and takes a clear input.
- Code/step arithmetic stays in the top-level FSM.

Test Plan:
- All parameters use defaults. Reset, then en=1, then 7 UP decisions: codes 192, 224, 240, 248, 252, 254, 255; state=FINE after the 7th; code_upd pulses 7 times.
- Reset, then en=1, then 7 DN decisions: final code 1, state=FINE. Then 1 further DN moves code to 0; the next DN triggers rail reacquire to COARSE with dco_code=128.
- Reach FINE, then 17 alternating UP/DN decisions (first loads last_dir, 16 flips): locked=1 after the 17th. Then 8 consecutive UP: locked=0, state=FINE after the 8th.
- pd_valid with both pd_late=1 and pd_early=1, and pd_valid with neither set, in each state: no code change, no code_upd, counters unchanged.
- In LOCKED, en=0 coincident with an UP decision: next cycle state=IDLE, dco_code=128, locked=0. Repeat the same scenario with rst=1 in place of en=0: identical result.
- With ADPLL_HOLDOVER_EN: in LOCKED, assert hold and apply 10 UP decisions; code, state and locked are unchanged. Deassert hold and tracking resumes. Without the macro, the same stimulus drops lock after 8 decisions.
